bcd_conv_sched: RTL and testbench
=================================

// Module: bcd_conv_sched
// PURPOSE
//  Shares one serial double-dabble binary->BCD converter between N requesters (balance display,
//  amount entry, PIN echo, ...). Round-robin arbitration, 1 bit per clock, tagged result pulse.
//  Sits between the bank FSM datapath and the 7-segment display drivers; replaces per-client converters.
// PARAMETERS
//  N_REQ   2   number of requesters (1..8)
//  BIN_W   14  binary operand width (max 16383)
//  BCD_W   16  result width, 4 BCD digits
// PORTS
//  clk       in   1            rising-edge clock
//  rst       in   1            synchronous, active-high reset
//  req       in   N_REQ        per-requester conversion request, level, held until gnt
//  bin_in    in   N_REQ*BIN_W  operands; requester k at [k*BIN_W +: BIN_W]
//  gnt       out  N_REQ        one-hot, 1-cycle pulse: operand of that requester sampled this cycle
//  busy      out  1            converter occupied (SHIFT or DONE)
//  bcd_out   out  BCD_W        result, holds until next DONE
//  out_valid out  1            1-cycle pulse, bcd_out/out_id/ovf valid
//  out_id    out  $clog2(N_REQ) index of requester owning the result (1 bit when N_REQ=1)
//  ovf       out  1            operand > 9999 (only driven with BCD_SAT_EN, else constant 0)
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, gnt=0, busy=0, out_valid=0, bcd_out=0, out_id=0, ovf=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: if |req, grant first requester at/after rr pointer (cyclic); gnt pulse same cycle (Mealy);
//   latch operand into shift reg, clear BCD accumulator, bit counter=BIN_W-1; rr ptr = granted+1 mod N_REQ.
//   No req: stay IDLE, gnt=0.
//  SHIFT: exactly BIN_W cycles; per cycle each digit >=5 gets +3 (all four digits from pre-adjust value),
//   then {acc,op} shifted left 1, op MSB enters acc[0]; bit shifted out of acc[15] discarded.
//   Counter hits 0 -> DONE.
//  DONE: register bcd_out, out_id, ovf; out_valid=1 for this cycle only; -> IDLE.
//  Latency: gnt at cycle T -> out_valid at T+BIN_W+1 (15 for defaults). Next gnt earliest T+BIN_W+2.
//  gnt never asserted while busy; req changes during busy are ignored; simultaneous reqs resolved by rr.
//  Requester deasserting req before gnt simply loses its turn; no partial state kept.
//  rst mid-conversion: abort, no out_valid, all outputs to reset values next cycle.
//  Operand > 9999 without macro: thousands digit overflows; result = low 16 bits, unspecified decimally.
// CONFIGURATION
//  BCD_SAT_EN defined: operand compared at grant; if > 9999 the conversion still takes full latency
//   but DONE outputs bcd_out=16'h9999, ovf=1. Operand <= 9999: ovf=0, normal result.
//  BCD_SAT_EN undefined: no comparator, ovf tied 0, results as above.
// STRUCTURE
//  bcd_pkg: BIN_W/BCD_W defaults, BCD_MAX_DEC=9999, BCD_SAT_CODE=16'h9999, state enum {IDLE,SHIFT,DONE}.
//  Sub-module bcd_dabble_step: combinational add-3-then-shift of {acc,op} by one bit; scheduler holds
//   FSM, rr arbiter, counter and registers.
// TESTING
//  1 req[0], bin=1234 -> gnt[0] at T, out_valid at T+15, bcd_out=16'h1234, out_id=0.
//  2 single reqs bin=0, 9, 10, 9999 -> 16'h0000, 16'h0009, 16'h0010, 16'h9999; ovf=0.
//  3 req=2'b11 held, bins 42/77 -> grant order 0,1,0,1; results 16'h0042 id0, 16'h0077 id1 alternate.
//  4 rst high at 7th SHIFT cycle -> no out_valid, busy=0, bcd_out=0 next cycle; new req converts normally.
//  5 BCD_SAT_EN, bin=12000 -> bcd_out=16'h9999, ovf=1; bin=9999 -> 16'h9999, ovf=0.
//  6 req[1] raised while busy -> no gnt until cycle after out_valid; gnt[1] then at IDLE.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the shared binary-to-BCD converter.
package bcd_pkg;

  localparam int BIN_W_DEF   = 14;
  localparam int BCD_W_DEF   = 16;
  localparam int BCD_MAX_DEC = 9999;

  localparam logic [15:0] BCD_SAT_CODE = 16'h9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift {acc,op} left by one.
module bcd_dabble_step #(
  parameter int BIN_W = 14,
  parameter int BCD_W = 16
) (
  input  logic [BCD_W-1:0] acc,
  input  logic [BIN_W-1:0] op,
  output logic [BCD_W-1:0] acc_next,
  output logic [BIN_W-1:0] op_next
);

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  // All digits are judged on their pre-adjust value; the top bit of acc falls off the shift.
  always_comb begin
    adj = acc;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    shifted  = {adj, op} << 1;
    acc_next = shifted[BCD_W+BIN_W-1:BIN_W];
    op_next  = shifted[BIN_W-1:0];
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one serial double-dabble converter between N_REQ requesters.
// Optional saturation of operands above 9999 is enabled by defining BCD_SAT_EN.
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int BIN_W = BIN_W_DEF,
  parameter int BCD_W = BCD_W_DEF,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] bin_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [BCD_W-1:0]       bcd_out,
  output logic                   out_valid,
  output logic [ID_W-1:0]        out_id,
  output logic                   ovf
);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  rr_next;
  logic [ID_W-1:0]  cur_id;
  logic             found;
  logic             grant;
  logic [BIN_W-1:0] op_sel;
  logic [BIN_W-1:0] op;
  logic [BIN_W-1:0] op_next;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;

  // First active requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    op_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req[k] && (k == (int'(rr_ptr) + i) % N_REQ)) begin
          found   = 1'b1;
          gnt_idx = ID_W'(k);
        end
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == ID_W'(k)) begin
        op_sel = bin_in[k*BIN_W +: BIN_W];
      end
    end
  end

  assign grant   = (state == IDLE) && found && !rst;
  assign rr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign busy    = (state != IDLE);

  always_comb begin
    gnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      gnt[k] = grant && (gnt_idx == ID_W'(k));
    end
  end

  bcd_dabble_step #(
    .BIN_W(BIN_W),
    .BCD_W(BCD_W)
  ) u_step (
    .acc     (acc),
    .op      (op),
    .acc_next(acc_next),
    .op_next (op_next)
  );

`ifdef BCD_SAT_EN
  logic sat_pend;
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Results are registered on the last shift so they appear during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      op        <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
`ifdef BCD_SAT_EN
      sat_pend  <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            op     <= op_sel;
            acc    <= '0;
            cnt    <= CNT_W'(BIN_W - 1);
            cur_id <= gnt_idx;
            rr_ptr <= rr_next;
            state  <= SHIFT;
`ifdef BCD_SAT_EN
            sat_pend <= (int'(op_sel) > BCD_MAX_DEC);
`endif
          end
        end
        SHIFT: begin
          acc <= acc_next;
          op  <= op_next;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_id    <= cur_id;
`ifdef BCD_SAT_EN
            bcd_out   <= sat_pend ? BCD_W'(BCD_SAT_CODE) : acc_next;
            ovf_q     <= sat_pend;
`else
            bcd_out   <= acc_next;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: decimal reference model, round-robin grant model, random traffic.
// Define BCD_SAT_EN for both RTL and bench to exercise saturation.
module tb_bcd_conv_sched;

  localparam int N_REQ = 2;
  localparam int BIN_W = 14;
  localparam int BCD_W = 16;
  localparam int ID_W  = 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*BIN_W-1:0] bin_in = '0;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [BCD_W-1:0]       bcd_out;
  logic                   out_valid;
  logic [ID_W-1:0]        out_id;
  logic                   ovf;

  bcd_conv_sched #(
    .N_REQ(N_REQ),
    .BIN_W(BIN_W),
    .BCD_W(BCD_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .bin_in   (bin_in),
    .gnt      (gnt),
    .busy     (busy),
    .bcd_out  (bcd_out),
    .out_valid(out_valid),
    .out_id   (out_id),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [15:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Decimal digits of the operand, saturating to 9999 when that feature is built in.
  function automatic logic [15:0] ref_bcd(int v);
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic ref_ovf(int v);
`ifdef BCD_SAT_EN
    return (v > 9999);
`else
    return (v < 0);
`endif
  endfunction

  function automatic int rand_operand();
`ifdef BCD_SAT_EN
    return int'($urandom_range(16383));
`else
    return int'($urandom_range(9999));
`endif
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one conversion occupies the converter for BIN_W+1 cycles after its grant.
  int               m_busy = 0;
  int               m_rr = 0;
  int               m_k;
  logic [N_REQ-1:0] m_gnt;
  always @(negedge clk) begin
    m_gnt = '0;
    checkOutput("busy", 32'(busy), 32'(m_busy != 0));
    if (rst) begin
      m_busy = 0;
      m_rr   = 0;
    end else if (m_busy == 0) begin
      for (int i = 0; i < N_REQ; i++) begin
        m_k = (m_rr + i) % N_REQ;
        if (req[m_k] && m_gnt == '0) begin
          m_gnt[m_k] = 1'b1;
          sb.push_back('{m_k, ref_bcd(int'(bin_in[m_k*BIN_W +: BIN_W])),
                         ref_ovf(int'(bin_in[m_k*BIN_W +: BIN_W])), cyc + BIN_W + 1});
          m_rr   = (m_k + 1) % N_REQ;
          m_busy = BIN_W + 1;
        end
      end
    end else begin
      m_busy--;
    end
    checkOutput("gnt", 32'(gnt), 32'(m_gnt));
  end

  // Monitor: pops the scoreboard whenever a result is presented.
  exp_t e;
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
        checkOutput("out_id", 32'(out_id), 32'(e.id));
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
        checkOutput("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_out_valid: got none, expected result %0h at cycle %0d", e.bcd, e.due);
    end
    if (rst) sb.delete();
  end

  task automatic waitGnt(int k, int limit);
    bit seen = 0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      if (gnt[k] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL gnt_timeout: got no gnt[%0d], expected one within %0d cycles", k, limit);
    end
  endtask

  task automatic waitIdle(int limit);
    bit idle = 0;
    for (int c = 0; c < limit && !idle; c++) begin
      @(negedge clk);
      if (busy === 1'b0 && sb.size() == 0) idle = 1;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d, expected idle", busy, sb.size());
    end
  endtask

  task automatic requestOne(int k, int v);
    @(posedge clk);
    #1;
    bin_in[k*BIN_W +: BIN_W] = BIN_W'(v);
    req[k] = 1'b1;
    waitGnt(k, 40);
    @(posedge clk);
    #1;
    req[k] = 1'b0;
    waitIdle(40);
  endtask

  // Random traffic: requests held until granted, occasionally withdrawn early.
  task automatic applyStimulus(int cycles, int pct);
    logic [N_REQ-1:0] g;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      for (int k = 0; k < N_REQ; k++) begin
        if (g[k]) begin
          req[k] = 1'b0;
        end else if (!req[k] && $urandom_range(99) < pct) begin
          bin_in[k*BIN_W +: BIN_W] = BIN_W'(rand_operand());
          req[k] = 1'b1;
        end else if (req[k] && $urandom_range(99) < 2) begin
          req[k] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_bcd_out", 32'(bcd_out), 32'd0);
    checkOutput("reset_out_id", 32'(out_id), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed single conversions");
    requestOne(0, 1234);
    requestOne(0, 0);
    requestOne(0, 9);
    requestOne(0, 10);
    requestOne(0, 9999);
    requestOne(1, 4321);
`ifdef BCD_SAT_EN
    requestOne(0, 12000);
    requestOne(1, 16383);
    requestOne(0, 9999);
`endif

    $display("[TB] two requesters held together");
    @(posedge clk);
    #1;
    bin_in[0*BIN_W +: BIN_W] = BIN_W'(42);
    bin_in[1*BIN_W +: BIN_W] = BIN_W'(77);
    req = 2'b11;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (|gnt) n++;
    end
    checkOutput("held_grant_count", 32'(n), 32'd4);
    @(posedge clk);
    #1 req = '0;
    waitIdle(40);

    $display("[TB] reset during conversion");
    @(posedge clk);
    #1;
    bin_in[0*BIN_W +: BIN_W] = BIN_W'(5678);
    req[0] = 1'b1;
    waitGnt(0, 40);
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_bcd_out", 32'(bcd_out), 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    requestOne(1, 8765);

    $display("[TB] request raised while busy");
    @(posedge clk);
    #1;
    bin_in[0*BIN_W +: BIN_W] = BIN_W'(321);
    req[0] = 1'b1;
    waitGnt(0, 40);
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bin_in[1*BIN_W +: BIN_W] = BIN_W'(654);
    req[1] = 1'b1;
    waitGnt(1, 40);
    @(posedge clk);
    #1 req[1] = 1'b0;
    waitIdle(40);

    $display("[TB] random traffic");
    applyStimulus(600, 15);
    @(posedge clk);
    #1 req = '0;
    waitIdle(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
